coax_rx_frontend: RTL and testbench

Conditions the raw coax receive pad signal before it enters coax_buffered_rx. It performs the following stages in order:
- synchronisation into clk;
- glitch filtering by consecutive-sample qualification;
- receiver blanking while transmitting, plus a post-TX holdoff;
- loopback selection of the TX serial stream.

It also reports line activity, driving the top-level irq logic, and keeps a saturating glitch counter that the control block reads.

---
 rtl/coax_rx_frontend.sv | 132 +++++++++++++
 tb/tb_coax_rx_frontend.sv | 389 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/coax_rx_frontend.sv
`timescale 1ns/1ps
// Receive-side conditioning for the coax line: pad synchroniser, consecutive-sample
// glitch filter, TX blanking with post-TX holdoff, loopback mux and line-activity detect.
module coax_rx_frontend #(
  parameter int SYNC_STAGES    = 2,
  parameter int FILTER_DEPTH   = 3,
  parameter int HOLDOFF_CLOCKS = 32,
  parameter int CLOCKS_PER_BIT = 16,
  parameter int IDLE_BITS      = 4
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       rx_pin,
  input  logic       tx_active,
  input  logic       tx,
  input  logic       loopback,
  input  logic       clear_count,
  output logic       rx,
  output logic       line_active,
  output logic [7:0] glitch_count
);

  localparam int CNT_W    = $clog2(FILTER_DEPTH) + 1;
  localparam int HOLD_W   = (HOLDOFF_CLOCKS > 0) ? $clog2(HOLDOFF_CLOCKS + 1) : 1;
  localparam int IDLE_MAX = IDLE_BITS * CLOCKS_PER_BIT;
  localparam int IDLE_W   = $clog2(IDLE_MAX + 1);

  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(FILTER_DEPTH - 1);
  localparam logic [HOLD_W-1:0] HOLD_LD  = HOLD_W'(HOLDOFF_CLOCKS);
  localparam logic [IDLE_W-1:0] IDLE_LIM = IDLE_W'(IDLE_MAX);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   txa_q;
  logic [HOLD_W-1:0]      hold_q, hold_d;
  logic                   filt_q, filt_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   rx_q, rx_d;
  logic [IDLE_W-1:0]      idle_q, idle_d;
  logic                   line_active_q, line_active_d;
  logic [7:0]             glitch_q, glitch_d;
  logic                   s;
  logic                   blank;
  logic                   glitch;

  assign s      = sync_q[SYNC_STAGES-1];
  assign sync_d = {sync_q[SYNC_STAGES-2:0], rx_pin};
  assign blank  = tx_active || (hold_q != '0);

  // Holdoff arms on the falling edge of tx_active and counts down to zero.
  always_comb begin
    hold_d = hold_q;
    if (txa_q && !tx_active) begin
      hold_d = HOLD_LD;
    end else if (hold_q != '0) begin
      hold_d = hold_q - 1'b1;
    end
  end

  // A level change is accepted only after FILTER_DEPTH consecutive disagreeing
  // samples; a disagreeing run that ends early is a rejected glitch.
  always_comb begin
    filt_d = filt_q;
    cnt_d  = cnt_q;
    glitch = 1'b0;
    if (blank && !loopback) begin
      filt_d = 1'b0;
      cnt_d  = '0;
    end else if (s != filt_q) begin
      if (cnt_q == CNT_LAST) begin
        filt_d = s;
        cnt_d  = '0;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end else if (cnt_q != '0) begin
      cnt_d  = '0;
      glitch = 1'b1;
    end
  end

  always_comb begin
    glitch_d = glitch_q;
    if (clear_count) begin
      glitch_d = '0;
    end else if (glitch && (glitch_q != 8'hFF)) begin
      glitch_d = glitch_q + 8'd1;
    end
  end

  always_comb begin
    rx_d = loopback ? tx : (blank ? 1'b0 : filt_q);
  end

  always_comb begin
    idle_d = idle_q;
    if (rx_d != rx_q) begin
      idle_d = '0;
    end else if (idle_q != IDLE_LIM) begin
      idle_d = idle_q + 1'b1;
    end
    line_active_d = (idle_d < IDLE_LIM);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_q        <= '0;
      txa_q         <= 1'b0;
      hold_q        <= '0;
      filt_q        <= 1'b0;
      cnt_q         <= '0;
      rx_q          <= 1'b0;
      idle_q        <= IDLE_LIM;
      line_active_q <= 1'b0;
      glitch_q      <= '0;
    end else begin
      sync_q        <= sync_d;
      txa_q         <= tx_active;
      hold_q        <= hold_d;
      filt_q        <= filt_d;
      cnt_q         <= cnt_d;
      rx_q          <= rx_d;
      idle_q        <= idle_d;
      line_active_q <= line_active_d;
      glitch_q      <= glitch_d;
    end
  end

  assign rx           = rx_q;
  assign line_active  = line_active_q;
  assign glitch_count = glitch_q;

endmodule

// File: tb/tb_coax_rx_frontend.sv
`timescale 1ns/1ps
// Bench for coax_rx_frontend: directed scenarios plus randomized traffic, all
// checked against a behavioural model of the receive conditioning rules.
module tb_coax_rx_frontend;

  localparam int SYNC     = 2;
  localparam int FD       = 3;
  localparam int HOLD     = 32;
  localparam int IDLE_MAX = 4 * 16;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       rx_pin = 1'b0;
  logic       tx_active = 1'b0;
  logic       tx = 1'b0;
  logic       loopback = 1'b0;
  logic       clear_count = 1'b0;
  logic       rx;
  logic       line_active;
  logic [7:0] glitch_count;

  int n_checks = 0;
  int n_fail   = 0;

  coax_rx_frontend dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .rx_pin       (rx_pin),
    .tx_active    (tx_active),
    .tx           (tx),
    .loopback     (loopback),
    .clear_count  (clear_count),
    .rx           (rx),
    .line_active  (line_active),
    .glitch_count (glitch_count)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  // ---------------- behavioural model ----------------
  int m_pipe[$];   // pad samples in flight through the synchroniser, newest first
  int m_filt, m_run, m_hold, m_txa_prev, m_rx, m_idle, m_la, m_gc;

  task automatic model_reset();
    m_pipe.delete();
    for (int i = 0; i < SYNC; i++) m_pipe.push_back(0);
    m_filt = 0; m_run = 0; m_hold = 0; m_txa_prev = 0;
    m_rx = 0; m_idle = IDLE_MAX; m_la = 0; m_gc = 0;
  endtask

  task automatic model_step();
    int s, blank, rx_n, glitch;
    s      = m_pipe[SYNC-1];
    blank  = (tx_active || m_hold > 0) ? 1 : 0;
    rx_n   = loopback ? int'(tx) : (blank ? 0 : m_filt);
    glitch = 0;
    if (blank && !loopback) begin
      m_filt = 0; m_run = 0;
    end else if (s != m_filt) begin
      // this sample extends the run of disagreeing samples by one
      if (m_run + 1 >= FD) begin m_filt = s; m_run = 0; end
      else m_run = m_run + 1;
    end else if (m_run > 0) begin
      glitch = 1; m_run = 0;
    end
    if (clear_count) m_gc = 0;
    else if (glitch) m_gc = (m_gc < 255) ? m_gc + 1 : 255;
    m_hold     = (m_txa_prev && !tx_active) ? HOLD : ((m_hold > 0) ? m_hold - 1 : 0);
    m_txa_prev = int'(tx_active);
    m_idle     = (rx_n != m_rx) ? 0 : ((m_idle < IDLE_MAX) ? m_idle + 1 : IDLE_MAX);
    m_la       = (m_idle < IDLE_MAX) ? 1 : 0;
    m_rx       = rx_n;
    m_pipe.push_front(int'(rx_pin));
    void'(m_pipe.pop_back());
  endtask

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) model_reset();
    else model_step();
  end

  // ---------------- driver ----------------
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    logic [9:0] exp;
    reset_n = 1'b0; rx_pin = 1'b0;
    for (int i = 0; i < 3; i++) begin
      cyc();
      n_checks++;
      if ({rx, line_active, glitch_count} !== 10'b0) begin
        n_fail++;
        $display("FAIL reset_hold cyc=%0d rx=%b la=%b gc=%0d expected all zero", i, rx, line_active, glitch_count);
      end
    end
    reset_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      cyc();
      exp = {m_rx[0], m_la[0], m_gc[7:0]};
      n_checks++;
      if ({rx, line_active, glitch_count} !== exp || exp !== 10'b0) begin
        n_fail++;
        $display("FAIL reset_release cyc=%0d rx=%b la=%b gc=%0d expected rx=0 la=0 gc=0", i, rx, line_active, glitch_count);
      end
    end
  endtask

  task automatic test_latency_width();
    logic [9:0] exp;
    int rise = -1;
    int ones = 0;
    rx_pin = 1'b1;
    for (int i = 1; i <= 30; i++) begin
      if (i == 11) rx_pin = 1'b0;
      cyc();
      exp = {m_rx[0], m_la[0], m_gc[7:0]};
      n_checks++;
      if ({rx, line_active, glitch_count} !== exp) begin
        n_fail++;
        $display("FAIL latency_model i=%0d got rx=%b la=%b gc=%0d expected rx=%b la=%b gc=%0d",
                 i, rx, line_active, glitch_count, exp[9], exp[8], exp[7:0]);
      end
      if (rx === 1'b1 && rise < 0) rise = i;
      if (rx === 1'b1) ones++;
      if (rise > 0 && i == rise + 1) begin
        n_checks++;
        if (line_active !== 1'b1) begin
          n_fail++;
          $display("FAIL latency_line_active got %b expected 1", line_active);
        end
      end
    end
    n_checks++;
    if (rise != SYNC + FD + 1) begin
      n_fail++;
      $display("FAIL latency_rise got %0d clocks expected %0d", rise, SYNC + FD + 1);
    end
    n_checks++;
    if (ones != 10) begin
      n_fail++;
      $display("FAIL pulse_width got %0d expected 10", ones);
    end
  endtask

  task automatic test_glitch();
    logic [9:0] exp;
    int rx_hi = 0;
    for (int p = 0; p < 300; p++) begin
      for (int c = 0; c < 20; c++) begin
        rx_pin = (c < 2);
        cyc();
        if (rx === 1'b1) rx_hi++;
        if (c == 19) begin
          exp = {m_rx[0], m_la[0], m_gc[7:0]};
          n_checks++;
          if ({rx, line_active, glitch_count} !== exp) begin
            n_fail++;
            $display("FAIL glitch_model pulse=%0d got rx=%b la=%b gc=%0d expected rx=%b la=%b gc=%0d",
                     p, rx, line_active, glitch_count, exp[9], exp[8], exp[7:0]);
          end
        end
      end
    end
    n_checks++;
    if (rx_hi != 0) begin
      n_fail++;
      $display("FAIL glitch_leak rx high for %0d clocks expected 0", rx_hi);
    end
    n_checks++;
    if (glitch_count !== 8'd255) begin
      n_fail++;
      $display("FAIL glitch_saturate got %0d expected 255", glitch_count);
    end
    clear_count = 1'b1;
    cyc();
    clear_count = 1'b0;
    n_checks++;
    if (glitch_count !== 8'd0) begin
      n_fail++;
      $display("FAIL glitch_clear got %0d expected 0", glitch_count);
    end
    // Glitch is detected on the fifth edge after the pulse starts; clear lands on it.
    for (int c = 0; c < 10; c++) begin
      rx_pin = (c < 2);
      clear_count = (c == 4);
      cyc();
    end
    clear_count = 1'b0;
    n_checks++;
    if (glitch_count !== 8'd0 || m_gc != 0) begin
      n_fail++;
      $display("FAIL clear_wins got %0d model %0d expected 0", glitch_count, m_gc);
    end
    for (int c = 0; c < 10; c++) begin
      rx_pin = (c < 2);
      cyc();
    end
    n_checks++;
    if (glitch_count !== 8'd1) begin
      n_fail++;
      $display("FAIL glitch_count_one got %0d expected 1", glitch_count);
    end
  endtask

  task automatic test_blanking();
    logic [9:0] exp;
    int first = -1;
    int leak = 0;
    rx_pin = 1'b1;
    repeat (12) cyc();
    tx_active = 1'b1;
    for (int i = 0; i < 50; i++) begin
      cyc();
      if (rx !== 1'b0) leak++;
    end
    n_checks++;
    if (leak != 0) begin
      n_fail++;
      $display("FAIL blank_during_tx rx high %0d clocks expected 0", leak);
    end
    tx_active = 1'b0;
    for (int i = 1; i <= 60; i++) begin
      cyc();
      exp = {m_rx[0], m_la[0], m_gc[7:0]};
      n_checks++;
      if ({rx, line_active, glitch_count} !== exp) begin
        n_fail++;
        $display("FAIL holdoff_model i=%0d got rx=%b la=%b gc=%0d expected rx=%b la=%b gc=%0d",
                 i, rx, line_active, glitch_count, exp[9], exp[8], exp[7:0]);
      end
      if (rx === 1'b1 && first < 0) first = i;
    end
    // Holdoff loads on the first edge after the fall, runs 32 clocks, then the
    // filter needs FD clocks and the output register one more.
    n_checks++;
    if (first != 1 + HOLD + FD + 1) begin
      n_fail++;
      $display("FAIL holdoff_release got %0d expected %0d", first, 1 + HOLD + FD + 1);
    end
  endtask

  task automatic test_loopback();
    logic exp_q[$];
    logic e;
    loopback = 1'b1;
    tx_active = 1'b1;
    tx = 1'b0;
    for (int i = 0; i < 100; i++) begin
      if (i % 16 == 0 && i > 0) tx = ~tx;
      exp_q.push_back(tx);
      cyc();
      e = exp_q.pop_front();
      n_checks++;
      if (rx !== e || line_active !== 1'b1) begin
        n_fail++;
        $display("FAIL loopback i=%0d got rx=%b la=%b expected rx=%b la=1", i, rx, line_active, e);
      end
    end
    tx = 1'b1;
    cyc();
    loopback = 1'b0;
    cyc();
    n_checks++;
    if (rx !== 1'b0 || m_rx != 0) begin
      n_fail++;
      $display("FAIL loopback_exit got rx=%b expected 0", rx);
    end
    tx_active = 1'b0;
    rx_pin = 1'b0;
    tx = 1'b0;
    repeat (60) cyc();
  endtask

  task automatic test_idle_and_reset();
    logic [9:0] exp;
    int fall = -1;
    int drop = -1;
    logic prev_rx, prev_la;
    repeat (80) cyc();
    prev_rx = rx;
    prev_la = line_active;
    rx_pin = 1'b1;
    for (int i = 1; i <= 120; i++) begin
      if (i == 11) rx_pin = 1'b0;
      cyc();
      exp = {m_rx[0], m_la[0], m_gc[7:0]};
      n_checks++;
      if ({rx, line_active, glitch_count} !== exp) begin
        n_fail++;
        $display("FAIL idle_model i=%0d got rx=%b la=%b gc=%0d expected rx=%b la=%b gc=%0d",
                 i, rx, line_active, glitch_count, exp[9], exp[8], exp[7:0]);
      end
      if (prev_rx === 1'b1 && rx === 1'b0) fall = i;
      if (prev_la === 1'b1 && line_active === 1'b0) drop = i;
      prev_rx = rx;
      prev_la = line_active;
    end
    n_checks++;
    if (fall < 0 || drop - fall != IDLE_MAX) begin
      n_fail++;
      $display("FAIL idle_timeout fall=%0d drop=%0d expected gap %0d", fall, drop, IDLE_MAX);
    end
    rx_pin = 1'b1;
    for (int i = 0; i < 20 && rx !== 1'b1; i++) cyc();
    n_checks++;
    if (rx !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_setup rx never rose, got %b expected 1", rx);
    end
    #2;
    reset_n = 1'b0;
    #1;
    n_checks++;
    if ({rx, line_active, glitch_count} !== 10'b0) begin
      n_fail++;
      $display("FAIL async_reset got rx=%b la=%b gc=%0d expected all zero", rx, line_active, glitch_count);
    end
    rx_pin = 1'b0;
    repeat (2) cyc();
    reset_n = 1'b1;
    for (int i = 0; i < 20; i++) begin
      cyc();
      n_checks++;
      if (rx !== 1'b0 || m_rx != 0) begin
        n_fail++;
        $display("FAIL post_reset_pulse i=%0d got rx=%b expected 0", i, rx);
      end
    end
  endtask

  task automatic test_random();
    logic [9:0] exp;
    int run_left = 0;
    int tx_left  = 0;
    for (int i = 0; i < 3000; i++) begin
      if (run_left == 0) begin
        rx_pin = ~rx_pin;
        run_left = $urandom_range(1, 7);
      end
      run_left--;
      if (tx_left > 0) begin
        tx_left--;
        if (tx_left == 0) tx_active = 1'b0;
      end else if ($urandom_range(0, 199) == 0) begin
        tx_active = 1'b1;
        tx_left = $urandom_range(5, 60);
      end
      if ($urandom_range(0, 149) == 0) loopback = ~loopback;
      if ($urandom_range(0, 7) == 0) tx = ~tx;
      clear_count = ($urandom_range(0, 63) == 0);
      cyc();
      exp = {m_rx[0], m_la[0], m_gc[7:0]};
      n_checks++;
      if ({rx, line_active, glitch_count} !== exp) begin
        n_fail++;
        $display("FAIL random i=%0d got rx=%b la=%b gc=%0d expected rx=%b la=%b gc=%0d",
                 i, rx, line_active, glitch_count, exp[9], exp[8], exp[7:0]);
      end
    end
    clear_count = 1'b0;
    loopback = 1'b0;
    tx_active = 1'b0;
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_latency_width();
    test_glitch();
    test_blanking();
    test_loopback();
    test_idle_and_reset();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
